imem_loader: RTL and testbench

- Writer side of the instruction-fetch path: receives a program as a serial byte stream, packs bytes into 32-bit MIPS words, and writes them into instruction memory starting at the text base.
- Holds the CPU (PC/fetch) off until the program, including its zero terminator word, is fully written.
- Sits between a host byte source (UART/bench) and the instruction memory write port; the fetch path is the reader of what this block writes.

---
 rtl/mips_pkg.sv | 15 +
 rtl/imem_loader_word_packer.sv | 42 ++++
 rtl/imem_loader.sv | 147 ++++++++++++++
 tb/tb_imem_loader.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS constants and the instruction-memory loader state encoding.
package mips_pkg;

    localparam logic [31:0] TEXT_BASE  = 32'h00400000;
    localparam int          WORD_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE,
        ASSEMBLE,
        WRITE,
        DONE,
        ERROR
    } loader_state_e;

endpackage

// File: rtl/imem_loader_word_packer.sv
// rtl/imem_loader_word_packer.sv - packs accepted bytes big-endian into 32-bit words.
// word is combinational so the completed word is available in the same cycle as its last byte.
module word_packer
    import mips_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_in,
    output logic        word_full,
    output logic [31:0] word
);

    logic [23:0] shift_q, shift_d;
    logic [1:0]  count_q, count_d;

    always_comb begin
        shift_d = shift_q;
        count_d = count_q;
        if (clear) begin
            count_d = 2'd0;
        end else if (accept) begin
            shift_d = {shift_q[15:0], byte_in};
            count_d = count_q + 2'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_q <= 24'h0;
            count_q <= 2'd0;
        end else begin
            shift_q <= shift_d;
            count_q <= count_d;
        end
    end

    assign word_full = accept && !clear && (count_q == 2'(WORD_BYTES - 1));
    assign word      = {shift_q, byte_in};

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - serial byte stream to instruction memory writer; holds the CPU until loaded.
// Optional running checksum of written words: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import mips_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = TEXT_BASE,
    parameter int          MAX_WORDS = 1024
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic [7:0]                   byte_in,
    input  logic                         byte_valid,
    output logic                         byte_ready,
    output logic                         wr_en,
    output logic [31:0]                  wr_addr,
    output logic [31:0]                  wr_data,
    output logic [$clog2(MAX_WORDS):0]   words_written,
    output logic                         cpu_hold,
    output logic                         done,
    output logic                         error,
    output logic [31:0]                  checksum
);

    localparam int CW = $clog2(MAX_WORDS) + 1;

    loader_state_e state_q;
    logic [CW-1:0] index_q;
    logic [CW-1:0] words_q;
    logic          byte_ready_q;
    logic          wr_en_q;
    logic [31:0]   wr_addr_q;
    logic [31:0]   wr_data_q;
    logic          cpu_hold_q;
    logic          done_q;
    logic          error_q;

    logic          load_start;
    logic          accept;
    logic          word_full;
    logic [31:0]   word;
    logic          last_slot;
    logic [31:0]   slot_addr;

    assign load_start = start && (state_q == IDLE || state_q == DONE || state_q == ERROR);
    assign accept     = byte_valid && byte_ready_q && (state_q == ASSEMBLE);
    assign last_slot  = (index_q == CW'(MAX_WORDS - 1));
    assign slot_addr  = BASE_ADDR + 32'(index_q) * 32'(WORD_BYTES);

    word_packer u_packer (
        .clock     (clock),
        .reset     (reset),
        .clear     (load_start),
        .accept    (accept),
        .byte_in   (byte_in),
        .word_full (word_full),
        .word      (word)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            index_q      <= '0;
            words_q      <= '0;
            byte_ready_q <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= BASE_ADDR;
            wr_data_q    <= 32'h0;
            cpu_hold_q   <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state_q      <= ASSEMBLE;
                        index_q      <= '0;
                        words_q      <= '0;
                        byte_ready_q <= 1'b1;
                        cpu_hold_q   <= 1'b1;
                        done_q       <= 1'b0;
                        error_q      <= 1'b0;
                    end
                end
                ASSEMBLE: begin
                    if (word_full) begin
                        state_q      <= WRITE;
                        byte_ready_q <= 1'b0;
                        wr_en_q      <= 1'b1;
                        wr_addr_q    <= slot_addr;
                        wr_data_q    <= word;
                    end
                end
                WRITE: begin
                    wr_en_q <= 1'b0;
                    words_q <= words_q + CW'(1);
                    // A zero word is the program terminator; it is written before fetch is released.
                    if (wr_data_q == 32'h0) begin
                        state_q    <= DONE;
                        done_q     <= 1'b1;
                        cpu_hold_q <= 1'b0;
                    end else if (last_slot) begin
                        state_q <= ERROR;
                        error_q <= 1'b1;
                    end else begin
                        state_q      <= ASSEMBLE;
                        index_q      <= index_q + CW'(1);
                        byte_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    byte_ready_q <= 1'b0;
                    wr_en_q      <= 1'b0;
                end
            endcase
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] csum_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            csum_q <= 32'h0;
        end else if (load_start) begin
            csum_q <= 32'h0;
        end else if (state_q == WRITE) begin
            csum_q <= csum_q + wr_data_q;
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = 32'h0;
`endif

    assign byte_ready    = byte_ready_q;
    assign wr_en         = wr_en_q;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign words_written = words_q;
    assign cpu_hold      = cpu_hold_q;
    assign done          = done_q;
    assign error         = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader against a program-level model.
module tb_imem_loader;

    localparam int          MAXW = 4;
    localparam logic [31:0] BASE = 32'h00400000;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [2:0]  words_written;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [31:0] checksum;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    int          got_cyc[$];
    int          hs_cyc[$];
    logic [7:0]  tx_q[$];
    logic [31:0] prog[$];
    logic [31:0] exp_words[$];
    logic [31:0] exp_sum;
    bit          exp_done;
    bit          pat[$];

    imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .byte_in       (byte_in),
        .byte_valid    (byte_valid),
        .byte_ready    (byte_ready),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .words_written (words_written),
        .cpu_hold      (cpu_hold),
        .done          (done),
        .error         (error),
        .checksum      (checksum)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (!reset && wr_en) begin
            got_addr.push_back(wr_addr);
            got_data.push_back(wr_data);
            got_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected writes: words in order up to and including the first zero, or until capacity.
    task automatic model_program;
        exp_words.delete();
        tx_q.delete();
        exp_sum = 32'h0;
        for (int i = 0; i < prog.size(); i++) begin
            exp_words.push_back(prog[i]);
            exp_sum += prog[i];
            if (prog[i] == 32'h0 || exp_words.size() == MAXW) break;
        end
        exp_done = (exp_words[exp_words.size()-1] == 32'h0);
        foreach (exp_words[i]) begin
            for (int b = 3; b >= 0; b--) tx_q.push_back(exp_words[i][8*b +: 8]);
        end
    endtask

    task automatic raw_start;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic pulse_start;
        got_addr.delete();
        got_data.delete();
        got_cyc.delete();
        hs_cyc.delete();
        raw_start();
    endtask

    // mode 0: continuous valid, 1: valid pattern from pat, 2: random gaps
    task automatic send_bytes(input int mode);
        int i = 0;
        int n = 0;
        while (i < tx_q.size() && n < 500) begin
            if (mode == 1 && n < pat.size()) byte_valid = pat[n];
            else if (mode == 2)              byte_valid = ($urandom_range(0, 3) != 0);
            else                             byte_valid = 1'b1;
            byte_in = byte_valid ? tx_q[i] : 8'($urandom);
            if (byte_valid && byte_ready) begin
                hs_cyc.push_back(cyc);
                i++;
            end
            n++;
            @(negedge clock);
        end
        byte_valid = 1'b0;
        if (i < tx_q.size()) check("send_timeout", 32'(i), 32'(tx_q.size()));
    endtask

    task automatic wait_end;
        int n = 0;
        while (!(done || error) && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) check("end_timeout", 32'(done || error), 32'd1);
    endtask

    task automatic compare_load(input string tag);
        int k;
        check({tag, "_nwr"}, 32'(got_data.size()), 32'(exp_words.size()));
        for (int i = 0; i < got_data.size() && i < exp_words.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), got_addr[i], BASE + 32'(4 * i));
            check($sformatf("%s_data%0d", tag, i), got_data[i], exp_words[i]);
            k = 4 * i + 3;
            if (k < hs_cyc.size()) check($sformatf("%s_lat%0d", tag, i), 32'(got_cyc[i] - hs_cyc[k]), 32'd1);
        end
        check({tag, "_done"},  32'(done), 32'(exp_done));
        check({tag, "_error"}, 32'(error), 32'(!exp_done));
        check({tag, "_hold"},  32'(cpu_hold), 32'(!exp_done));
        check({tag, "_rdy"},   32'(byte_ready), 32'd0);
        check({tag, "_words"}, 32'(words_written), 32'(exp_words.size()));
`ifdef IMEM_LOADER_CHECKSUM_EN
        check({tag, "_csum"},  checksum, exp_sum);
`else
        check({tag, "_csum"},  checksum, 32'h0);
`endif
    endtask

    task automatic run_prog(input string tag, input int mode);
        model_program();
        pulse_start();
        send_bytes(mode);
        wait_end();
        compare_load(tag);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        byte_in    = 8'h0;
        byte_valid = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_rdy",   32'(byte_ready), 32'd0);
        check("rst_wren",  32'(wr_en), 32'd0);
        check("rst_addr",  wr_addr, BASE);
        check("rst_data",  wr_data, 32'h0);
        check("rst_words", 32'(words_written), 32'd0);
        check("rst_hold",  32'(cpu_hold), 32'd1);
        check("rst_done",  32'(done), 32'd0);
        check("rst_err",   32'(error), 32'd0);
        check("rst_csum",  checksum, 32'h0);
        reset = 1'b0;
        @(negedge clock);

        prog = '{32'h08100001, 32'h0};
        run_prog("basic", 0);
        if (got_cyc.size() == 2) check("basic_thru", 32'(got_cyc[1] - got_cyc[0]), 32'd5);

        // reload from DONE: fetch held again as soon as the new load starts
        prog = '{32'h12345678, 32'h0};
        model_program();
        pulse_start();
        check("reload_hold", 32'(cpu_hold), 32'd1);
        check("reload_done", 32'(done), 32'd0);
        check("reload_rdy",  32'(byte_ready), 32'd1);
        send_bytes(0);
        wait_end();
        compare_load("reload");

        prog = '{32'h2000002A, 32'h0};
        pat  = '{1, 0, 0, 1, 1, 0, 1};
        run_prog("gap", 1);

        prog = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        run_prog("ovf", 0);
        byte_valid = 1'b1;
        repeat (6) begin
            byte_in = 8'($urandom);
            @(negedge clock);
        end
        byte_valid = 1'b0;
        check("ovf_nocons", 32'(got_data.size()), 32'd4);
        check("ovf_words",  32'(words_written), 32'd4);
        check("ovf_err",    32'(error), 32'd1);

        // start during ASSEMBLE must not disturb the partial word
        prog = '{32'hA1B2C3D4, 32'h0};
        model_program();
        pulse_start();
        begin
            logic [7:0] all_b[$];
            all_b = tx_q;
            tx_q  = all_b[0:1];
            send_bytes(0);
            raw_start();
            tx_q  = all_b[2:$];
            send_bytes(0);
        end
        wait_end();
        compare_load("startign");

        prog = '{32'h0};
        model_program();
        pulse_start();
        tx_q = '{8'hDE, 8'hAD};
        send_bytes(0);
        #2 reset = 1'b1;
        #1;
        check("rmid_rdy",  32'(byte_ready), 32'd0);
        check("rmid_hold", 32'(cpu_hold), 32'd1);
        check("rmid_addr", wr_addr, BASE);
        @(negedge clock);
        reset = 1'b0;
        run_prog("rmid", 0);

        prog = '{32'h00000001, 32'hFFFFFFFF, 32'h0};
        run_prog("csum", 2);
        check("csum_wrap", checksum, 32'h0);

        for (int t = 0; t < 30; t++) begin
            prog.delete();
            for (int w = 0; w < MAXW; w++) begin
                logic [31:0] v;
                v = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
                if ($urandom_range(0, 2) != 0 && v == 32'h0) v = 32'h1;
                prog.push_back(v);
            end
            run_prog($sformatf("rnd%0d", t), 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
